// File: rtl/ocp_reg_target.sv
// ocp_reg_target: register-bank responder for the 8-bit OCP-style bridge.
// Holds N_RW read/write bytes, exposes N_RO status bytes, a sticky error
// register at 0xFE and a constant ID at 0xFF. Reads answer with a one-cycle
// SResp pulse RD_LATENCY cycles after the accept cycle; writes are posted.
module ocp_reg_target #(
  parameter int         N_RW        = 4,
  parameter int         N_RO        = 4,
  parameter int         ACCEPT_WAIT = 0,
  parameter int         RD_LATENCY  = 1,
  parameter logic [7:0] RESET_VAL   = 8'h00,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          MCmd,
  input  logic [7:0]          MAddr,
  input  logic [7:0]          MData,
  output logic                SCmdAccept,
  output logic [7:0]          SData,
  output logic [1:0]          SResp,
  output logic [8*N_RW-1:0]   reg_rw_out,
  input  logic [8*N_RO-1:0]   status_in,
  output logic                wr_pulse,
  output logic [5:0]          wr_index
);

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [1:0] RESP_DVA = 2'b01;
  localparam logic [1:0] RESP_ERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT, S_RESP} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rw_q [N_RW];
  logic [1:0] errstat_q, errstat_d;
  logic [7:0] rdata_q;
  logic [1:0] resp_q;
  logic       wr_pulse_q;
  logic [5:0] wr_index_q;

  logic       rw_hit, ro_hit, rd_err;
  logic [7:0] rd_data;
  logic       accept, is_wr, is_rd, is_illegal, resp_now;

  assign accept     = (state_q == S_ACCEPT);
  assign is_wr      = (MCmd == CMD_WR);
  assign is_rd      = (MCmd == CMD_RD);
  assign is_illegal = (MCmd != CMD_IDLE) && !is_wr && !is_rd;

  // Address decode and read-data mux for the command currently presented.
  always_comb begin
    rw_hit  = 1'b0;
    ro_hit  = 1'b0;
    rd_err  = 1'b0;
    rd_data = 8'h00;
    for (int i = 0; i < N_RW; i++) begin
      if (MAddr == 8'(i)) begin
        rw_hit  = 1'b1;
        rd_data = rw_q[i];
      end
    end
    for (int i = 0; i < N_RO; i++) begin
      if (MAddr == 8'(128 + i)) begin
        ro_hit  = 1'b1;
        rd_data = status_in[8*i +: 8];
      end
    end
    if (!rw_hit && !ro_hit) begin
      if (MAddr == 8'hFE)      rd_data = {6'b0, errstat_q};
      else if (MAddr == 8'hFF) rd_data = ID_VALUE;
      else                     rd_err  = 1'b1;
    end
  end

  // Sticky error update: a read of 0xFE clears, a concurrent error set wins.
  always_comb begin
    errstat_d = errstat_q;
    if (accept) begin
      if (is_rd && MAddr == 8'hFE) errstat_d = 2'b00;
      if (is_wr && !rw_hit)        errstat_d[0] = 1'b1;
      if (is_illegal)              errstat_d[1] = 1'b1;
    end
  end

  // Next-state logic: IDLE -> (WAIT) -> ACCEPT -> (RESP) -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (MCmd != CMD_IDLE) begin
          if (ACCEPT_WAIT == 0) begin
            state_d = S_ACCEPT;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(ACCEPT_WAIT);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (is_rd) begin
          state_d = S_RESP;
          cnt_d   = 4'(RD_LATENCY - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, register bank and captured response; all effects land at the accept edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      errstat_q  <= 2'b00;
      rdata_q    <= 8'h00;
      resp_q     <= 2'b00;
      wr_pulse_q <= 1'b0;
      wr_index_q <= 6'd0;
      for (int i = 0; i < N_RW; i++) rw_q[i] <= RESET_VAL;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      errstat_q  <= errstat_d;
      wr_pulse_q <= 1'b0;
      if (accept) begin
        if (is_wr && rw_hit) begin
          for (int i = 0; i < N_RW; i++) begin
            if (MAddr == 8'(i)) rw_q[i] <= MData;
          end
          wr_pulse_q <= 1'b1;
          wr_index_q <= MAddr[5:0];
        end
        if (is_rd) begin
          rdata_q <= rd_err ? 8'h00 : rd_data;
          resp_q  <= rd_err ? RESP_ERR : RESP_DVA;
        end
      end
    end
  end

  assign resp_now   = (state_q == S_RESP) && (cnt_q == 4'd0);
  assign SCmdAccept = accept;
  assign SResp      = resp_now ? resp_q : 2'b00;
  assign SData      = resp_now ? rdata_q : 8'h00;
  assign wr_pulse   = wr_pulse_q;
  assign wr_index   = wr_index_q;

  for (genvar g = 0; g < N_RW; g++) begin : g_rw_out
    assign reg_rw_out[8*g +: 8] = rw_q[g];
  end

endmodule
